pipe_step_ctrl: RTL and testbench
=================================

// Module: pipe_step_ctrl
// PURPOSE
//   Run/step controller and writeback trace buffer for the 5-stage pipeline. Gates the
//   pipeline advance enable so the core can be halted, stepped N cycles, or run freely.
//   Captures each writeback-mux value with its cycle stamp into a FIFO drained by a host.
//   Sits between the host/debug interface and the pipeline top (pipe_en in, outMuxWb out).
// PARAMETERS
//   DATA_W       32  width of writeback data (outMuxWb)
//   CNT_W        16  width of step count and cycle stamp counter
//   TRACE_DEPTH   8  trace FIFO entries; power of two, >=2
// PORTS
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   cmd_valid    in   1       command present
//   cmd_ready    out  1       command accepted when cmd_valid&cmd_ready
//   cmd_mode     in   2       00 HALT, 01 STEP, 10 RUN, 11 reserved (treated as HALT)
//   cmd_count    in   CNT_W   cycles to advance in STEP mode
//   pipe_en      out  1       pipeline advance enable for this cycle
//   wb_data      in   DATA_W  writeback-mux value from the pipeline
//   wb_valid     in   1       wb_data is a real writeback this cycle
//   trace_data   out  DATA_W  FIFO head data
//   trace_cycle  out  CNT_W   FIFO head cycle stamp
//   trace_valid  out  1       FIFO non-empty
//   trace_ready  in   1       host pops head when trace_valid&trace_ready
//   trace_ovf    out  1       sticky: a capture was dropped because FIFO full
//   busy         out  1       state != IDLE
//   cycle_cnt    out  CNT_W   enabled-cycle counter
// BEHAVIOUR
//   - Reset (async assert, sync release): state IDLE, pipe_en=0, cmd_ready=1, busy=0,
//     cycle_cnt=0, FIFO empty (trace_valid=0, trace_data/trace_cycle=0), trace_ovf=0.
//   - States: IDLE, STEP, RUN. cmd_ready=1 in IDLE and RUN; 0 in STEP.
//   - IDLE: STEP cmd with cmd_count>0 -> STEP, remaining=cmd_count; cmd_count=0 is
//     accepted and ignored (stay IDLE). RUN -> RUN. HALT/reserved -> stay IDLE.
//   - STEP: pipe_en=1 each cycle; remaining decrements; when remaining==1 that cycle is the
//     last enabled cycle, next state IDLE. Exactly cmd_count enabled cycles, no more.
//   - RUN: pipe_en=1 every cycle; HALT/reserved cmd -> IDLE, pipe_en=0 from the next
//     cycle; STEP cmd in RUN -> STEP with new count; RUN cmd in RUN is a no-op.
//   - pipe_en is registered: command accepted at edge k -> pipe_en=1 in cycle k+1.
//   - cycle_cnt increments on each edge where pipe_en=1; wraps 2^CNT_W-1 -> 0 silently.
//   - Capture: on an edge with pipe_en=1 and wb_valid=1, push {wb_data, cycle_cnt} (value
//     before increment). wb_valid ignored when pipe_en=0.
//   - FIFO full and push without pop -> entry dropped, trace_ovf set until reset.
//     Full with simultaneous pop+push -> both succeed, no overflow.
//   - Empty with simultaneous push+pop -> push lands; trace_valid rises next cycle (no
//     fall-through); pop ignored when trace_valid=0.
//   - Occupancy counter covers 0..TRACE_DEPTH; pointers wrap mod TRACE_DEPTH.
//   - rst_n low mid-STEP/RUN: pipe_en drops immediately (async), FIFO contents discarded.
// TESTING
//   1 Reset: rst_n=0 mid-RUN -> pipe_en=0, busy=0, cycle_cnt=0, trace_valid=0 immediately.
//   2 STEP count=3, wb_valid=1, wb_data=0xA,0xB,0xC -> pipe_en high exactly 3 cycles,
//     FIFO pops {0xA,0},{0xB,1},{0xC,2}; busy falls after 3rd enabled cycle.
//   3 STEP count=0 -> cmd accepted, pipe_en stays 0, cycle_cnt unchanged.
//   4 RUN, trace_ready=0, wb_valid=1 for 10 cycles (DEPTH=8) -> 8 entries, trace_ovf=1;
//     then HALT -> pipe_en=0 one cycle after accept.
//   5 FIFO full, pop+push same cycle -> occupancy stays 8, trace_ovf stays 0, order kept.
//   6 CNT_W=4, RUN 17 cycles -> cycle_cnt wraps 15->0, stamps 15 then 0 in trace.

Source files
------------

// File: rtl/pipe_step_ctrl_if.sv
// Host-side command and trace-drain channels of the run/step controller.
// master = host/debug side, slave = pipe_step_ctrl.
interface pipe_step_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_mode;
  logic [CNT_W-1:0]  cmd_count;
  logic [DATA_W-1:0] trace_data;
  logic [CNT_W-1:0]  trace_cycle;
  logic              trace_valid;
  logic              trace_ready;

  modport master (
    output cmd_valid, cmd_mode, cmd_count, trace_ready,
    input  cmd_ready, trace_data, trace_cycle, trace_valid
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_count, trace_ready,
    output cmd_ready, trace_data, trace_cycle, trace_valid
  );
endinterface

// File: rtl/pipe_step_ctrl.sv
// Run/step controller gating the pipeline advance enable, plus a writeback trace
// FIFO stamping each captured value with the enabled-cycle count.
module pipe_step_ctrl #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int TRACE_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_step_ctrl_if.slave    host,
  output logic               pipe_en,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               wb_valid,
  output logic               trace_ovf,
  output logic               busy,
  output logic [CNT_W-1:0]   cycle_cnt
);
  localparam int PTR_W   = $clog2(TRACE_DEPTH);
  localparam int OCC_W   = $clog2(TRACE_DEPTH + 1);
  localparam int ENTRY_W = DATA_W + CNT_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STEP   = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_RUN  = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               pipe_en_q, pipe_en_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic               ovf_q, ovf_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [ENTRY_W-1:0] mem_q [TRACE_DEPTH];

  logic cmd_fire, push, pop, full, wr_en;

  assign host.cmd_ready = (state_q != ST_STEP);
  assign cmd_fire       = host.cmd_valid & host.cmd_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    if (state_q == ST_STEP) begin
      remaining_d = remaining_q - CNT_W'(1);
      if (remaining_q == CNT_W'(1)) state_d = ST_IDLE;
    end else if (cmd_fire) begin
      // IDLE and RUN decode commands identically; a zero-count STEP leaves state alone.
      case (host.cmd_mode)
        MODE_STEP: begin
          if (host.cmd_count != '0) begin
            state_d     = ST_STEP;
            remaining_d = host.cmd_count;
          end
        end
        MODE_RUN: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
    pipe_en_d   = (state_d != ST_IDLE);
    cycle_cnt_d = pipe_en_q ? cycle_cnt_q + CNT_W'(1) : cycle_cnt_q;
  end

  assign push  = pipe_en_q & wb_valid;
  assign pop   = host.trace_ready & (occ_q != '0);
  assign full  = (occ_q == OCC_W'(TRACE_DEPTH));
  assign wr_en = push & (~full | pop);

  always_comb begin
    ovf_d    = ovf_q | (push & full & ~pop);
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (!wr_en && pop) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      pipe_en_q   <= 1'b0;
      cycle_cnt_q <= '0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      for (int unsigned i = 0; i < TRACE_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      pipe_en_q   <= pipe_en_d;
      cycle_cnt_q <= cycle_cnt_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      if (wr_en) mem_q[wr_ptr_q] <= {wb_data, cycle_cnt_q};
    end
  end

  assign pipe_en          = pipe_en_q;
  assign busy             = (state_q != ST_IDLE);
  assign cycle_cnt        = cycle_cnt_q;
  assign trace_ovf        = ovf_q;
  assign host.trace_valid = (occ_q != '0);
  assign host.trace_data  = host.trace_valid ? mem_q[rd_ptr_q][ENTRY_W-1:CNT_W] : '0;
  assign host.trace_cycle = host.trace_valid ? mem_q[rd_ptr_q][CNT_W-1:0] : '0;
endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Directed bench for pipe_step_ctrl: a 32/16/8 instance and a 8/4/4 instance for
// cycle-stamp wrap. Expected trace entries are queued at issue and checked on pop.
module tb_pipe_step_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default widths
  pipe_step_ctrl_if #(.DATA_W(32), .CNT_W(16)) ifa ();
  logic        pipe_en_a, trace_ovf_a, busy_a, wb_valid_a;
  logic [31:0] wb_data_a;
  logic [15:0] cycle_cnt_a;

  pipe_step_ctrl #(.DATA_W(32), .CNT_W(16), .TRACE_DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .host(ifa), .pipe_en(pipe_en_a),
    .wb_data(wb_data_a), .wb_valid(wb_valid_a), .trace_ovf(trace_ovf_a),
    .busy(busy_a), .cycle_cnt(cycle_cnt_a)
  );

  // Instance B: narrow counter to exercise stamp wrap
  pipe_step_ctrl_if #(.DATA_W(8), .CNT_W(4)) ifb ();
  logic       pipe_en_b, trace_ovf_b, busy_b, wb_valid_b;
  logic [7:0] wb_data_b;
  logic [3:0] cycle_cnt_b;

  pipe_step_ctrl #(.DATA_W(8), .CNT_W(4), .TRACE_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .host(ifb), .pipe_en(pipe_en_b),
    .wb_data(wb_data_b), .wb_valid(wb_valid_b), .trace_ovf(trace_ovf_b),
    .busy(busy_b), .cycle_cnt(cycle_cnt_b)
  );

  localparam logic [1:0] M_HALT = 2'b00, M_STEP = 2'b01, M_RUN = 2'b10;

  int total = 0;
  int bad   = 0;
  logic [47:0] sb_a [$];
  logic [11:0] sb_b [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [1:0] mode, input logic [15:0] count);
    ifa.cmd_valid = 1'b1;
    ifa.cmd_mode  = mode;
    ifa.cmd_count = count;
    for (int i = 0; i < 20 && !ifa.cmd_ready; i++) tick();
    chk("cmd_ready_a", ifa.cmd_ready, 1);
    tick();
    ifa.cmd_valid = 1'b0;
  endtask

  task automatic drain_a();
    for (int i = 0; i < 40 && sb_a.size() != 0; i++) tick();
    chk("drain_a", sb_a.size(), 0);
    tick();
  endtask

  task automatic drain_b();
    for (int i = 0; i < 40 && sb_b.size() != 0; i++) tick();
    chk("drain_b", sb_b.size(), 0);
    tick();
  endtask

  int n_en;

  initial begin
    ifa.cmd_valid = 0; ifa.cmd_mode = M_HALT; ifa.cmd_count = '0; ifa.trace_ready = 0;
    ifb.cmd_valid = 0; ifb.cmd_mode = M_HALT; ifb.cmd_count = '0; ifb.trace_ready = 0;
    wb_valid_a = 0; wb_data_a = '0; wb_valid_b = 0; wb_data_b = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && ifa.trace_valid && ifa.trace_ready) begin
          if (sb_a.size() == 0) begin
            total++; bad++;
            $display("FAIL trace_a_extra: got %0h expected no entry", {ifa.trace_data, ifa.trace_cycle});
          end else chk("trace_a", {ifa.trace_data, ifa.trace_cycle}, sb_a.pop_front());
        end
        if (rst_n && ifb.trace_valid && ifb.trace_ready) begin
          if (sb_b.size() == 0) begin
            total++; bad++;
            $display("FAIL trace_b_extra: got %0h expected no entry", {ifb.trace_data, ifb.trace_cycle});
          end else chk("trace_b", {ifb.trace_data, ifb.trace_cycle}, sb_b.pop_front());
        end
      end
    join_none

    // Reset state
    #2;
    chk("rst_pipe_en", pipe_en_a, 0);
    chk("rst_cmd_ready", ifa.cmd_ready, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_cycle_cnt", cycle_cnt_a, 0);
    chk("rst_trace_valid", ifa.trace_valid, 0);
    chk("rst_trace_head", {ifa.trace_data, ifa.trace_cycle}, 0);
    chk("rst_ovf", trace_ovf_a, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // STEP 3 with capture; wb_valid during the accept cycle must be ignored
    ifa.trace_ready = 1; wb_valid_a = 1; wb_data_a = 32'hFF;
    sb_a.push_back({32'hA, 16'd0});
    sb_a.push_back({32'hB, 16'd1});
    sb_a.push_back({32'hC, 16'd2});
    send_a(M_STEP, 16'd3);
    n_en = 0;
    for (int i = 0; i < 6; i++) begin
      wb_data_a = 32'hA + 32'(i);
      if (i == 0) chk("step_cmd_ready", ifa.cmd_ready, 0);
      if (pipe_en_a) n_en++;
      tick();
    end
    chk("step3_en_cycles", n_en, 3);
    chk("step3_busy", busy_a, 0);
    chk("step3_cycle_cnt", cycle_cnt_a, 3);
    drain_a();

    // STEP 0 is accepted and ignored
    send_a(M_STEP, 16'd0);
    n_en = 0;
    for (int i = 0; i < 4; i++) begin
      if (pipe_en_a) n_en++;
      tick();
    end
    chk("step0_en_cycles", n_en, 0);
    chk("step0_cycle_cnt", cycle_cnt_a, 3);
    chk("step0_trace_valid", ifa.trace_valid, 0);

    // RUN 10 captures into depth-8 FIFO with no drain, HALT on the 10th
    ifa.trace_ready = 0; wb_valid_a = 0;
    for (int i = 0; i < 8; i++) sb_a.push_back({32'h100 + 32'(i), 16'(3 + i)});
    send_a(M_RUN, 16'd0);
    n_en = 0;
    for (int i = 0; i < 10; i++) begin
      wb_valid_a = 1; wb_data_a = 32'h100 + 32'(i);
      if (pipe_en_a) n_en++;
      if (i == 9) begin ifa.cmd_valid = 1; ifa.cmd_mode = M_HALT; end
      tick();
    end
    ifa.cmd_valid = 0; wb_valid_a = 0;
    chk("run_en_cycles", n_en, 10);
    chk("halt_pipe_en", pipe_en_a, 0);
    chk("run_cycle_cnt", cycle_cnt_a, 13);
    chk("run_ovf", trace_ovf_a, 1);
    ifa.trace_ready = 1;
    drain_a();
    chk("ovf_sticky", trace_ovf_a, 1);

    // Async reset in the middle of RUN with FIFO occupied
    ifa.trace_ready = 0;
    send_a(M_RUN, 16'd0);
    wb_valid_a = 1;
    tick(); tick(); tick();
    chk("pre_rst_valid", ifa.trace_valid, 1);
    rst_n = 0;
    #1;
    chk("arst_pipe_en", pipe_en_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_cycle_cnt", cycle_cnt_a, 0);
    chk("arst_trace_valid", ifa.trace_valid, 0);
    chk("arst_ovf", trace_ovf_a, 0);
    wb_valid_a = 0;
    tick(); tick();
    rst_n = 1;
    tick();

    // Fill to 8, then simultaneous pop+push while full
    for (int i = 0; i < 8; i++) sb_a.push_back({32'h300 + 32'(i), 16'(i)});
    sb_a.push_back({32'h400, 16'd8});
    sb_a.push_back({32'h401, 16'd9});
    send_a(M_STEP, 16'd8);
    for (int i = 0; i < 8; i++) begin
      wb_valid_a = 1; wb_data_a = 32'h300 + 32'(i);
      tick();
    end
    wb_valid_a = 0;
    chk("fill_ovf", trace_ovf_a, 0);
    chk("fill_valid", ifa.trace_valid, 1);
    send_a(M_STEP, 16'd2);
    for (int i = 0; i < 2; i++) begin
      wb_valid_a = 1; ifa.trace_ready = 1; wb_data_a = 32'h400 + 32'(i);
      tick();
    end
    wb_valid_a = 0; ifa.trace_ready = 0;
    chk("full_popush_ovf", trace_ovf_a, 0);
    chk("full_popush_cnt", cycle_cnt_a, 10);
    send_a(M_STEP, 16'd1);
    wb_valid_a = 1; wb_data_a = 32'h500;
    tick();
    wb_valid_a = 0;
    chk("still_full_ovf", trace_ovf_a, 1);
    ifa.trace_ready = 1;
    drain_a();
    chk("drained_valid", ifa.trace_valid, 0);

    // Instance B: 17 RUN cycles wrap the 4-bit stamp
    ifb.trace_ready = 1;
    for (int i = 0; i < 17; i++) sb_b.push_back({8'(i), 4'(i)});
    ifb.cmd_valid = 1; ifb.cmd_mode = M_RUN;
    tick();
    ifb.cmd_valid = 0;
    for (int i = 0; i < 17; i++) begin
      wb_valid_b = 1; wb_data_b = 8'(i);
      if (i == 16) begin ifb.cmd_valid = 1; ifb.cmd_mode = M_HALT; end
      tick();
    end
    ifb.cmd_valid = 0; wb_valid_b = 0;
    chk("wrap_pipe_en", pipe_en_b, 0);
    chk("wrap_cycle_cnt", cycle_cnt_b, 1);
    chk("wrap_ovf", trace_ovf_b, 0);
    drain_b();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
